addsub_accum: RTL and testbench
===============================

# addsub_accum

Sequencing accumulator that sits directly upstream of, and wraps, the team's combinational add/subtract unit. It accepts a start command with an initial value, then consumes a handshaked stream of (operand, opcode) beats. Each beat drives the add/subtract datapath and registers the result into a running accumulator. It reports the final value with a one-cycle `done` pulse, plus sticky overflow and illegal-opcode flags.

## Interface
- `SIZE`, default 4: accumulator and operand width in bits.
- `MAXLEN`, default 8: maximum number of beats per run (≥1); the run ends on the beat that reaches this count even without `in_last`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `init` in SIZE: initial accumulator value, captured with `start`.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat; high only in RUN.
- `in_data` in SIZE: operand (right-hand side).
- `in_op` in 2: opcode; 1 = add, 0 = sub, 2 = hold, 3 = illegal.
- `in_last` in 1: this beat is the final one of the run.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse, result final.
- `result` out SIZE: accumulator register, driven continuously.
- `ovf` out 1: sticky carry/borrow flag for the current run.
- `err` out 1: sticky illegal-opcode flag for the current run.

## Operation
- **States:** IDLE, RUN, DONE (2-bit encoding).
- **IDLE → RUN** on `start`:
  - acc ← `init`; count ← 0.
  - `ovf` and `err` are cleared.
- **RUN:** `in_ready` = 1. A beat transfers when `in_valid` && `in_ready`. On transfer:
  - op 1: acc ← acc + `in_data` (mod 2^SIZE); `ovf` sets if carry-out = 1.
  - op 0: acc ← acc − `in_data` (mod 2^SIZE); `ovf` sets if `in_data` > acc (borrow).
  - op 2: acc unchanged.
  - op 3: acc unchanged; `err` sets.
  - count ← count + 1. Count width is clog2(MAXLEN+1).
- **RUN → DONE** on a transfer where `in_last` = 1 or count+1 == MAXLEN.
- **DONE:** `done` = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- **Hold behaviour:** `result`, `ovf` and `err` hold their values in IDLE until the next `start`.
- **Arithmetic:** unsigned; operands and result are exactly SIZE bits. The carry/borrow is computed on a SIZE+1-bit intermediate.

## Timing
- **Reset values:** state IDLE, acc/`result` 0, count 0, `done` 0, `busy` 0, `in_ready` 0, `ovf` 0, `err` 0.
- `start` → `in_ready` high the next cycle.
- Beat latency: `result` reflects a beat one cycle after its transfer edge.
- `done` is asserted in the cycle after the final beat transfers; `result` is final in that cycle.
- `in_valid` low in RUN: no transfer, count unchanged, no timeout.
- `start` in RUN/DONE: ignored.
- `in_valid` in IDLE/DONE: ignored (`in_ready` = 0).
- `start` together with `in_valid` in IDLE: only `start` takes effect.
- Reset asserted mid-run: all state returns immediately to reset values; no `done` is issued.
- Back-to-back runs: `start` may be asserted in the cycle after `done`. Minimum run period is 3 cycles (1 start cycle, 1 beat cycle, 1 DONE cycle).

## Configuration
- Macro: `ADDSUB_ACCUM_SAT_EN`.
- **Defined:** saturating arithmetic. An add that carries clamps acc to 2^SIZE−1; a sub that borrows clamps acc to 0. `ovf` still sets.
- **Undefined:** wrap-around modulo 2^SIZE, as described above.
- Either way, the handshake and timing are identical.

## Structure
- **Shared package `addsub_pkg`:**
  - Opcode constants: OP_SUB = 2'd0, OP_ADD = 2'd1, OP_HOLD = 2'd2, OP_RSV = 2'd3.
  - FSM state constants: S_IDLE, S_RUN, S_DONE.
- **Sub-module `addsub_core`:** combinational. Inputs: `left`, `right`, op. Outputs: SIZE-bit sum and a 1-bit carry/borrow. It contains the saturation logic under the macro.
- **Top level:** FSM, counter, accumulator register and flags.

## Test plan
All scenarios use SIZE = 4 and MAXLEN = 8 unless stated.

1. **Basic run:** `start`, `init` = 3; beats add 5, sub 2 (`in_last`). Expect `done` one cycle after the 2nd beat, `result` = 6, `ovf` = 0, `err` = 0.
2. **Add overflow:** `init` = 14, add 3 with `in_last`. Without the macro: `result` = 1, `ovf` = 1. With the macro: `result` = 15, `ovf` = 1.
3. **Sub borrow:** `init` = 2, sub 5 with `in_last`. Without the macro: `result` = 13, `ovf` = 1. With the macro: `result` = 0, `ovf` = 1.
4. **Hold and illegal opcodes:** `init` = 7; beats op 2 (data 9), then op 3 (data 4, `in_last`). Expect `result` = 7, `err` = 1, `ovf` = 0.
5. **MAXLEN termination:** MAXLEN = 4, `init` = 0, four add-1 beats with `in_last` = 0 and idle gaps between beats. Expect `done` after the 4th transfer, `result` = 4, and gaps not counted.
6. **Reset mid-run:** `start`, `init` = 5, one add 2, then `rst` low mid-RUN. Expect all outputs 0 immediately and no `done`. After release, `start` again with `init` = 1, add 1 with `in_last` → `result` = 2.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared opcode and FSM state definitions for the add/subtract accumulator.
package addsub_pkg;

  localparam logic [1:0] OP_SUB  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_HOLD = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract unit with carry/borrow out.
// Saturating mode is enabled by defining ADDSUB_ACCUM_SAT_EN.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] left,
  input  logic [SIZE-1:0] right,
  input  logic [1:0]      op,
  output logic [SIZE-1:0] sum,
  output logic            carry
);

  logic [SIZE:0] ext;

  always_comb begin
    ext = {1'b0, left};
    case (op)
      OP_ADD:  ext = {1'b0, left} + {1'b0, right};
      // Top bit of the widened difference is the borrow.
      OP_SUB:  ext = {1'b0, left} - {1'b0, right};
      default: ext = {1'b0, left};
    endcase
    carry = ext[SIZE];
`ifdef ADDSUB_ACCUM_SAT_EN
    if (carry) begin
      sum = (op == OP_ADD) ? '1 : '0;
    end else begin
      sum = ext[SIZE-1:0];
    end
`else
    sum = ext[SIZE-1:0];
`endif
  end

endmodule

// File: rtl/addsub_accum.sv
// Sequencing accumulator around addsub_core: start/init, handshaked beats, done pulse,
// sticky ovf/err flags. Saturation selected by ADDSUB_ACCUM_SAT_EN (see addsub_core).
module addsub_accum
  import addsub_pkg::*;
#(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned MAXLEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] init,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [1:0]      in_op,
  input  logic            in_last,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            ovf,
  output logic            err
);

  localparam int unsigned CntW = $clog2(MAXLEN + 1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] core_sum;
  logic            core_carry;

  addsub_core #(
    .SIZE(SIZE)
  ) u_core (
    .left (acc_q),
    .right(in_data),
    .op   (in_op),
    .sum  (core_sum),
    .carry(core_carry)
  );

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          acc_d = core_sum;
          ovf_d = ovf_q | core_carry;
          err_d = err_q | (in_op == OP_RSV);
          cnt_d = cnt_inc;
          if (in_last || (cnt_inc == CntW'(MAXLEN))) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Handshake/status outputs are registered from the next state.
    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = acc_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench for addsub_accum: a MAXLEN=8 and a MAXLEN=4 instance share stimulus.
module tb_addsub_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] init = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [1:0] in_op = '0;
  logic       in_last = 1'b0;

  logic       rdy8, busy8, done8, ovf8, err8;
  logic [3:0] res8;
  logic       rdy4, busy4, done4, ovf4, err4;
  logic [3:0] res4;

  always #5 clk = ~clk;

  addsub_accum #(.SIZE(4), .MAXLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .init(init), .in_valid(in_valid), .in_ready(rdy8),
    .in_data(in_data), .in_op(in_op), .in_last(in_last), .busy(busy8), .done(done8),
    .result(res8), .ovf(ovf8), .err(err8)
  );

  addsub_accum #(.SIZE(4), .MAXLEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .init(init), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_op(in_op), .in_last(in_last), .busy(busy4), .done(done4),
    .result(res4), .ovf(ovf4), .err(err4)
  );

  logic       sel4 = 1'b0;
  logic       o_ready, o_busy, o_done, o_ovf, o_err;
  logic [3:0] o_res;
  assign o_ready = sel4 ? rdy4 : rdy8;
  assign o_busy  = sel4 ? busy4 : busy8;
  assign o_done  = sel4 ? done4 : done8;
  assign o_res   = sel4 ? res4 : res8;
  assign o_ovf   = sel4 ? ovf4 : ovf8;
  assign o_err   = sel4 ? err4 : err8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] res;
    logic       ovf;
    logic       err;
  } exp_t;
  exp_t sb[$];

  int m_acc, m_cnt;
  int m_max = 8;
  bit m_ovf, m_err;

  // All drivers are entered and left on a falling edge.
  task automatic send_start(input logic [3:0] v);
    start = 1'b1;
    init  = v;
    @(negedge clk);
    start = 1'b0;
    m_acc = int'(v);
    m_cnt = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] op, input logic [3:0] d, input logic last);
    int s;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (op == 2'd1) begin
      s = m_acc + int'(d);
      if (s > 15) begin
        m_ovf = 1'b1;
`ifdef ADDSUB_ACCUM_SAT_EN
        s = 15;
`endif
      end
      m_acc = s & 15;
    end else if (op == 2'd0) begin
      s = m_acc - int'(d);
      if (s < 0) begin
        m_ovf = 1'b1;
`ifdef ADDSUB_ACCUM_SAT_EN
        s = 0;
`endif
      end
      m_acc = s & 15;
    end else if (op == 2'd3) begin
      m_err = 1'b1;
    end
    m_cnt++;
    if (last || m_cnt == m_max) sb.push_back(exp_t'{res: 4'(m_acc), ovf: m_ovf, err: m_err});
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({o_ready, o_busy, o_done, o_res, o_ovf, o_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b res=%0d ovf=%b err=%b want all 0",
               o_ready, o_busy, o_done, o_res, o_ovf, o_err);
    end
  endtask

  task automatic test_basic;
    int lat;
    exp_t e;
    send_start(4'd3);
    checks++;
    if ({o_ready, o_busy, o_res} !== {2'b11, 4'd3}) begin
      errors++;
      $display("FAIL basic_after_start: got rdy=%b busy=%b res=%0d want 1 1 3",
               o_ready, o_busy, o_res);
    end
    send_beat(2'd1, 4'd5, 1'b0);
    checks++;
    if ({o_res, o_done} !== {4'(m_acc), 1'b0}) begin
      errors++;
      $display("FAIL basic_beat_latency: got res=%0d done=%b want %0d 0", o_res, o_done, m_acc);
    end
    send_beat(2'd0, 4'd2, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d want 0", lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL basic_result: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({o_res, o_ovf, o_err} !== {e.res, e.ovf, e.err}) begin
        errors++;
        $display("FAIL basic_result: got res=%0d ovf=%b err=%b want %0d %b %b",
                 o_res, o_ovf, o_err, e.res, e.ovf, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy, o_ready, o_res} !== {3'b000, 4'd6}) begin
      errors++;
      $display("FAIL basic_idle_hold: got done=%b busy=%b rdy=%b res=%0d want 0 0 0 6",
               o_done, o_busy, o_ready, o_res);
    end
  endtask

  // One-beat and two-beat runs whose outcome is checked against the scoreboard.
  task automatic test_arith(input logic [3:0] iv, input logic [1:0] op0, input logic [3:0] d0,
                            input bit two, input logic [1:0] op1, input logic [3:0] d1);
    int lat;
    exp_t e;
    send_start(iv);
    send_beat(op0, d0, !two);
    if (two) send_beat(op1, d1, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != 0 || sb.size() == 0) begin
      errors++;
      $display("FAIL arith_done init=%0d: latency=%0d queued=%0d want 0 and >0",
               iv, lat, sb.size());
    end else begin
      e = sb.pop_front();
      if ({o_res, o_ovf, o_err} !== {e.res, e.ovf, e.err}) begin
        errors++;
        $display("FAIL arith_result init=%0d: got res=%0d ovf=%b err=%b want %0d %b %b",
                 iv, o_res, o_ovf, o_err, e.res, e.ovf, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if ({o_done, o_res, o_ovf, o_err} !== {1'b0, e.res, e.ovf, e.err}) begin
      errors++;
      $display("FAIL arith_idle_hold init=%0d: got done=%b res=%0d ovf=%b err=%b",
               iv, o_done, o_res, o_ovf, o_err);
    end
  endtask

  task automatic test_ignore;
    int lat;
    exp_t e;
    // start with a simultaneous beat: only the start takes effect
    in_valid = 1'b1;
    in_op    = 2'd1;
    in_data  = 4'd3;
    send_start(4'd4);
    in_valid = 1'b0;
    checks++;
    if (o_res !== 4'd4) begin
      errors++;
      $display("FAIL ignore_beat_with_start: got res=%0d want 4", o_res);
    end
    // start during RUN must not reload the accumulator
    start = 1'b1;
    init  = 4'd9;
    send_beat(2'd0, 4'd1, 1'b1);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != 0 || sb.size() == 0) begin
      errors++;
      $display("FAIL ignore_done: latency=%0d queued=%0d want 0 and >0", lat, sb.size());
    end else begin
      e = sb.pop_front();
      if (o_res !== e.res) begin
        errors++;
        $display("FAIL ignore_start_in_run: got res=%0d want %0d", o_res, e.res);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_maxlen;
    int lat;
    exp_t e;
    sel4  = 1'b1;
    m_max = 4;
    send_start(4'd0);
    for (int i = 0; i < 4; i++) begin
      send_beat(2'd1, 4'd1, 1'b0);
      if (i < 3) begin
        checks++;
        if ({o_done, o_busy, o_res} !== {2'b01, 4'(i + 1)}) begin
          errors++;
          $display("FAIL maxlen_beat%0d: got done=%b busy=%b res=%0d want 0 1 %0d",
                   i, o_done, o_busy, o_res, i + 1);
        end
        @(negedge clk);
        @(negedge clk);
      end
    end
    wait_done(lat);
    checks++;
    if (lat != 0 || sb.size() == 0) begin
      errors++;
      $display("FAIL maxlen_done: latency=%0d queued=%0d want 0 and >0", lat, sb.size());
    end else begin
      e = sb.pop_front();
      if ({o_res, o_ovf, o_err} !== {e.res, e.ovf, e.err}) begin
        errors++;
        $display("FAIL maxlen_result: got res=%0d ovf=%b err=%b want %0d %b %b",
                 o_res, o_ovf, o_err, e.res, e.ovf, e.err);
      end
    end
    sel4  = 1'b0;
    m_max = 8;
    // realign the MAXLEN=8 instance, which is still in RUN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int   lat;
    bit   seen;
    exp_t e;
    send_start(4'd5);
    send_beat(2'd1, 4'd2, 1'b0);
    checks++;
    if (o_res !== 4'd7) begin
      errors++;
      $display("FAIL rstmid_before: got res=%0d want 7", o_res);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_busy, o_done, o_res, o_ovf, o_err} !== 9'd0) begin
      errors++;
      $display("FAIL rstmid_async: got rdy=%b busy=%b done=%b res=%0d ovf=%b err=%b want all 0",
               o_ready, o_busy, o_done, o_res, o_ovf, o_err);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      if (o_done) seen = 1'b1;
    end
    checks++;
    if (seen || sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got done_seen=%b queued=%0d want 0 0", seen, sb.size());
    end
    send_start(4'd1);
    send_beat(2'd1, 4'd1, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != 0 || sb.size() == 0) begin
      errors++;
      $display("FAIL rstmid_rerun_done: latency=%0d queued=%0d", lat, sb.size());
    end else begin
      e = sb.pop_front();
      if ({o_res, o_ovf, o_err} !== {e.res, e.ovf, e.err}) begin
        errors++;
        $display("FAIL rstmid_rerun: got res=%0d ovf=%b err=%b want %0d %b %b",
                 o_res, o_ovf, o_err, e.res, e.ovf, e.err);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_basic;
    test_arith(4'd14, 2'd1, 4'd3, 1'b0, 2'd0, 4'd0);
    test_arith(4'd2, 2'd0, 4'd5, 1'b0, 2'd0, 4'd0);
    test_arith(4'd7, 2'd2, 4'd9, 1'b1, 2'd3, 4'd4);
    test_arith(4'd9, 2'd1, 4'd6, 1'b1, 2'd0, 4'd12);
    test_ignore;
    test_maxlen;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
